// File: rtl/sat_rr_sched.sv
// sat_rr_sched
// Round-robin scheduler that shares one saturating narrowing stage
// (NBW_IN -> NBW_OUT, signed) among NUM_REQ requesters.
// Ports:
//   i_clk, i_rst_n       clock, asynchronous active-low reset
//   i_valid / o_ready    per-requester handshake (one-hot or zero ready)
//   i_data               packed samples, requester k at [k*NBW_IN +: NBW_IN]
//   o_valid / i_ready    downstream handshake on the registered output stage
//   o_data, o_id, o_sat  saturated sample, source index, clamp flag
//   i_clr_cnt            synchronous clear of the saturation counter
//   o_sat_cnt            sticky count of saturated samples handed downstream
module sat_rr_sched #(
   parameter int NUM_REQ = 4,
   parameter int NBW_IN  = 8,
   parameter int NBW_OUT = 7,
   parameter int NBW_CNT = 16,
   parameter int NBW_ID  = $clog2(NUM_REQ)
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic [NUM_REQ-1:0]        i_valid,
   output logic [NUM_REQ-1:0]        o_ready,
   input  logic [NUM_REQ*NBW_IN-1:0] i_data,
   output logic                      o_valid,
   input  logic                      i_ready,
   output logic [NBW_OUT-1:0]        o_data,
   output logic [NBW_ID-1:0]         o_id,
   output logic                      o_sat,
   input  logic                      i_clr_cnt,
   output logic [NBW_CNT-1:0]        o_sat_cnt
);

   localparam int                 NBW_TOP   = NBW_IN - NBW_OUT + 1;
   localparam logic [NBW_ID:0]    NUM_REQ_W = (NBW_ID+1)'(NUM_REQ);
   localparam logic [NBW_ID-1:0]  LAST_ID   = NBW_ID'(NUM_REQ - 1);
   localparam logic [NBW_CNT-1:0] CNT_MAX   = {NBW_CNT{1'b1}};

   // Returns {clamp_flag, narrowed_sample}.
   function automatic logic [NBW_OUT:0] sat_fn(input logic [NBW_IN-1:0] x);
      logic [NBW_TOP-1:0] top;
      logic [NBW_OUT:0]   res;
      top = x[NBW_IN-1 -: NBW_TOP];
      // All dropped bits equal to the new sign bit: value fits.
      if ((&top) || !(|top)) begin
         res = {1'b0, x[NBW_OUT-1:0]};
      end else if (x[NBW_IN-1]) begin
         res = {1'b1, 1'b1, {(NBW_OUT-1){1'b0}}};
      end else begin
         res = {1'b1, 1'b0, {(NBW_OUT-1){1'b1}}};
      end
      return res;
   endfunction

   logic [NBW_IN-1:0]  samp_s [NUM_REQ];
   logic [NBW_ID-1:0]  ptr_q, ptr_d;
   logic [NBW_ID-1:0]  grant_s;
   logic [NBW_ID:0]    cand_s;
   logic               found_s;
   logic               ld_s;
   logic               xfer_s;
   logic [NUM_REQ-1:0] ready_s;
   logic [NBW_OUT:0]   sat_res_s;
   logic               valid_q, valid_d;
   logic [NBW_OUT-1:0] data_q, data_d;
   logic [NBW_ID-1:0]  id_q, id_d;
   logic               sat_q, sat_d;
   logic [NBW_CNT-1:0] cnt_q, cnt_d;

   for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign samp_s[k] = i_data[k*NBW_IN +: NBW_IN];
   end

   // Round-robin search: first valid requester starting at ptr, wrapping.
   always_comb begin
      found_s = 1'b0;
      grant_s = '0;
      cand_s  = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         cand_s = {1'b0, ptr_q} + (NBW_ID+1)'(off);
         if (cand_s >= NUM_REQ_W) begin
            cand_s = cand_s - NUM_REQ_W;
         end else begin
            cand_s = cand_s;
         end
         if (!found_s && i_valid[cand_s[NBW_ID-1:0]]) begin
            found_s = 1'b1;
            grant_s = cand_s[NBW_ID-1:0];
         end else begin
            found_s = found_s;
         end
      end
   end

   // Output stage can load when empty or draining; reset forces ready low.
   assign ld_s      = !valid_q || i_ready;
   assign xfer_s    = found_s && ld_s && i_rst_n;
   assign sat_res_s = sat_fn(samp_s[grant_s]);

   // One-hot ready toward the granted requester.
   always_comb begin
      ready_s = '0;
      if (xfer_s) begin
         ready_s[grant_s] = 1'b1;
      end else begin
         ready_s = '0;
      end
   end

   // Next state of pointer, output stage and saturation counter.
   always_comb begin
      ptr_d   = ptr_q;
      valid_d = valid_q;
      data_d  = data_q;
      id_d    = id_q;
      sat_d   = sat_q;
      cnt_d   = cnt_q;
      if (xfer_s) begin
         ptr_d   = (grant_s == LAST_ID) ? '0 : grant_s + 1'b1;
         valid_d = 1'b1;
         data_d  = sat_res_s[NBW_OUT-1:0];
         id_d    = grant_s;
         sat_d   = sat_res_s[NBW_OUT];
      end else if (ld_s) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      // Clear has priority; the count saturates instead of wrapping.
      if (i_clr_cnt) begin
         cnt_d = '0;
      end else if (valid_q && i_ready && sat_q && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + 1'b1;
      end else begin
         cnt_d = cnt_q;
      end
   end

   // State registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ptr_q   <= '0;
         valid_q <= 1'b0;
         data_q  <= '0;
         id_q    <= '0;
         sat_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         id_q    <= id_d;
         sat_q   <= sat_d;
         cnt_q   <= cnt_d;
      end
   end

   assign o_ready   = ready_s;
   assign o_valid   = valid_q;
   assign o_data    = data_q;
   assign o_id      = id_q;
   assign o_sat     = sat_q;
   assign o_sat_cnt = cnt_q;

endmodule

// File: doc/sat_rr_sched.md
# sat_rr_sched

Round-robin scheduler that shares one saturating narrowing stage (NBW_IN to NBW_OUT, signed) among NUM_REQ requesters. Each requester offers a signed sample over a valid/ready handshake. The block grants one requester per cycle, saturates the granted sample and holds it in a registered output stage with its source ID and a saturation flag. It also keeps a running count of saturation events for status readout. It sits between parallel producer lanes (e.g. per-channel accumulators) and a single narrower downstream consumer.

## Interface
- NUM_REQ, 4, number of requesters; must be at least 2.
- NBW_IN, 8, input sample width, signed.
- NBW_OUT, 7, output sample width, signed; NBW_IN > NBW_OUT is required.
- NBW_CNT, 16, width of the saturation event counter.
- NBW_ID, $clog2(NUM_REQ), derived; width of the requester ID.
- i_clk  in  1  single clock; all logic is rising-edge.
- i_rst_n  in  1  reset; asynchronous assert, active-low.
- i_valid  in  NUM_REQ  per-requester sample valid.
- o_ready  out  NUM_REQ  per-requester accept; at most one bit high.
- i_data  in  NUM_REQ*NBW_IN  packed samples; requester k occupies bits [k*NBW_IN +: NBW_IN].
- o_valid  out  1  output sample valid.
- i_ready  in  1  downstream accept.
- o_data  out  NBW_OUT  saturated signed sample.
- o_id  out  NBW_ID  index of the requester that produced o_data.
- o_sat  out  1  high when o_data was clamped.
- i_clr_cnt  in  1  synchronous clear of o_sat_cnt.
- o_sat_cnt  out  NBW_CNT  number of accepted samples that saturated.

## Operation
- Load enable: ld = !o_valid || i_ready. The output register can take a new sample when it is empty or is being drained in the same cycle.
- Arbitration:
  - Round-robin pointer ptr, range 0..NUM_REQ-1.
  - Search order is ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - The winner g is the first k in that order with i_valid[k] high.
  - o_ready[g] = ld. All other o_ready bits are 0.
  - If no i_valid bit is high, o_ready is all zero.
- Transfer on requester k: i_valid[k] && o_ready[k]. On a transfer the following take effect at the next edge:
  - ptr <= (g+1) mod NUM_REQ.
  - o_data <= sat(i_data[g]).
  - o_id <= g.
  - o_sat <= the clamp flag.
  - o_valid <= 1.
- ptr holds when there is no transfer.
- If ld is high and there is no transfer, o_valid <= 0. o_data, o_id and o_sat hold their previous values.
- Saturation, with MAX = 2^(NBW_OUT-1)-1 and MIN = -2^(NBW_OUT-1):
  - If the upper NBW_IN-NBW_OUT+1 bits of the input are all equal, pass the low NBW_OUT bits unchanged with flag 0.
  - Otherwise output MAX if the input sign is 0, or MIN if the input sign is 1, with flag 1.
- Counter:
  - o_sat_cnt increments by 1 on each downstream handshake (o_valid && i_ready) where o_sat is 1.
  - It sticks at all-ones and does not wrap.
  - When i_clr_cnt is high, the next value is 0. Clear wins over a same-cycle increment.
- Requester obligation: once i_valid[k] is high it stays high, with i_data stable, until o_ready[k] is sampled high. The block does not check this.

## Timing
- Reset values: o_valid 0, o_data 0, o_id 0, o_sat 0, o_sat_cnt 0, ptr 0.
- o_ready is all zero while i_rst_n is low. It is combinational from i_valid, o_valid, i_ready and ptr.
- Latency is 1 cycle from a transfer to o_valid. Throughput is 1 sample per cycle when i_ready is held high.
- Backpressure: while o_valid && !i_ready, o_data, o_id and o_sat are stable and all o_ready bits are 0.
- Fairness: with all requesters continuously valid and i_ready high, grants follow 0,1,2,...,NUM_REQ-1,0,... Any valid requester is granted within NUM_REQ transfers.
- Reset mid-operation:
  - An in-flight output sample is discarded.
  - ptr returns to 0 and the counter is cleared.
  - After release, the first grant goes to the lowest-index valid requester.

## Test plan
- Reset, then idle (all i_valid=0) for 5 cycles -> o_valid=0, o_ready=0000, o_sat_cnt=0 throughout.
- Saturation (NBW_IN=8, NBW_OUT=7, only requester 1 valid):
  - Send 100, -100, 50, -64, 63 with i_ready=1.
  - o_data must be 63, -64, 50, -64, 63 with o_sat 1,1,0,0,0 and o_id=1.
  - o_sat_cnt must reach 2.
- All four requesters valid, i_ready=1, 8 transfers -> o_id sequence 0,1,2,3,0,1,2,3 on consecutive cycles.
- Backpressure:
  - Drop i_ready for 3 cycles while o_valid=1.
  - Required: o_data and o_id stable, o_ready=0000 during the stall.
  - When i_ready returns, the next grant follows ptr with no sample lost or duplicated.
- Counter: preload via 65535 saturating samples (NBW_CNT=16).
  - One more saturating sample -> o_sat_cnt stays 65535.
  - Assert i_clr_cnt on the same cycle as a saturating handshake -> o_sat_cnt=0.
- Assert i_rst_n low mid-stream with o_valid=1 and ptr=2 -> o_valid=0 immediately (asynchronous). After release with requesters 1 and 3 valid, the first o_id is 1.
